dmem_arbiter: RTL and testbench

- Shares the single-port data RAM between the CPU load/store port and an I/O burst port used for data dump/load.
- The RAM has a combinational read and a write on the clock edge.
- The arbiter sits between the core's memory stage and the RAM. It drives the RAM's address, write-data and write-enable, and returns read data to each requester.
- CPU accesses are single-cycle. I/O transfers are atomic word bursts, with anti-starvation for I/O.

---
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU load/store
// port and an I/O burst port. CPU accesses pass straight through to the RAM
// with no added latency. I/O bursts are atomic, and an I/O request that the
// CPU keeps blocking is forced in after STARVE_LIMIT cycles.
// Optional feature macro: ARB_BOUNDS_CHECK_EN enables word-index bounds
// checking against MEM_WORDS, with a sticky err flag. Without the macro,
// err is tied low.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int MEM_WORDS    = 102
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_base,
  input  logic [LEN_W-1:0]  io_len,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic              io_beat,
  output logic [LEN_W-1:0]  io_idx,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              err
);

`ifdef ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0]   WORD_LIMIT = ADDR_W'(MEM_WORDS);
  localparam logic [ADDR_W-1:0]   ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                dir_we_q, dir_we_d;
  logic                err_q, err_d;

  logic                io_grant;
  logic                oob;
  logic [ADDR_W-1:0]   beat_addr;

  // True when a byte address lands beyond the last RAM word (feature builds only)
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return BOUNDS_EN && ((a >> 2) >= WORD_LIMIT);
  endfunction

  assign io_grant  = io_req && (!cpu_req || (starve_q == STARVE_MAX));
  assign beat_addr = base_q + (ADDR_W'(beat_q) << 2);

  // Arbitration, RAM steering and next-state logic; all outputs forced low in reset
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    beat_d    = beat_q;
    len_d     = len_q;
    base_d    = base_q;
    dir_we_d  = dir_we_q;
    err_d     = err_q;
    oob       = 1'b0;

    cpu_rdata = '0;
    cpu_stall = 1'b0;
    io_ack    = 1'b0;
    io_beat   = 1'b0;
    io_idx    = '0;
    io_rdata  = '0;
    io_done   = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;

    unique case (state_q)
      IDLE: begin
        if (io_grant) begin
          io_ack    = 1'b1;
          cpu_stall = cpu_req;
          base_d    = io_base & ALIGN_MASK;
          len_d     = io_len;
          dir_we_d  = io_we;
          beat_d    = '0;
          starve_d  = '0;
          state_d   = BURST;
        end else if (cpu_req) begin
          oob       = out_of_range(cpu_addr);
          mem_a     = cpu_addr;
          mem_wd    = cpu_wdata;
          mem_we    = cpu_we && !oob;
          cpu_rdata = oob ? '0 : mem_rd;
          if (oob) err_d = 1'b1;
          if (!io_req) starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + STARVE_W'(1);
        end else begin
          starve_d = '0;
        end
      end
      BURST: begin
        oob       = out_of_range(beat_addr);
        io_beat   = 1'b1;
        io_idx    = beat_q;
        mem_a     = beat_addr;
        cpu_stall = cpu_req;
        if (dir_we_q) begin
          mem_we = !oob;
          mem_wd = io_wdata;
        end else begin
          io_rdata = oob ? '0 : mem_rd;
        end
        if (oob) err_d = 1'b1;
        if (beat_q == len_q - LEN_W'(1)) state_d = DONE;
        else beat_d = beat_q + LEN_W'(1);
      end
      DONE: begin
        io_done   = 1'b1;
        cpu_stall = cpu_req;
        beat_d    = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err = BOUNDS_EN ? err_q : 1'b0;

    if (!rst_n) begin
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      io_ack    = 1'b0;
      io_beat   = 1'b0;
      io_idx    = '0;
      io_rdata  = '0;
      io_done   = 1'b0;
      mem_we    = 1'b0;
      mem_a     = '0;
      mem_wd    = '0;
      err       = 1'b0;
    end
  end

  // State, burst context, starvation counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      base_q   <= '0;
      dir_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      base_q   <= base_d;
      dir_we_q <= dir_we_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors against a small RAM model,
// covering CPU pass-through, I/O bursts, length encoding, starvation and
// reset mid-burst.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_base;
  logic [3:0]  io_len;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic        io_beat;
  logic [3:0]  io_idx;
  logic [31:0] io_rdata;
  logic        io_done;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        err;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] ram [0:127];

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_base   (io_base),
    .io_len    (io_len),
    .io_wdata  (io_wdata),
    .io_ack    (io_ack),
    .io_beat   (io_beat),
    .io_idx    (io_idx),
    .io_rdata  (io_rdata),
    .io_done   (io_done),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .err       (err)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM model: combinational read, write on the clock edge
  assign mem_rd = ram[mem_a[8:2]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_a[8:2]] <= mem_wd;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca,
                               input logic [31:0] cd, input logic ir, input logic iw,
                               input logic [31:0] ib, input logic [3:0] il,
                               input logic [31:0] iwd);
    @(negedge clk);
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    io_req    = ir;
    io_we     = iw;
    io_base   = ib;
    io_len    = il;
    io_wdata  = iwd;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
  endtask

  // Directed test sequence
  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'h1234_5678;
    io_req    = 1'b1;
    io_we     = 1'b1;
    io_base   = 32'h20;
    io_len    = 4'd4;
    io_wdata  = 32'h0;
    #2;
    checkOutput("rst_mem_we",    {31'b0, mem_we},    32'h0);
    checkOutput("rst_mem_a",     mem_a,              32'h0);
    checkOutput("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    checkOutput("rst_io_ack",    {31'b0, io_ack},    32'h0);
    checkOutput("rst_cpu_rdata", cpu_rdata,          32'h0);
    checkOutput("rst_err",       {31'b0, err},       32'h0);

    idleCycle();
    rst_n = 1'b1;
    idleCycle();
    checkOutput("idle_mem_a",  mem_a,           32'h0);
    checkOutput("idle_mem_we", {31'b0, mem_we}, 32'h0);

    // CPU write then read of 0x10, zero latency
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("cpu_wr_mem_we", {31'b0, mem_we},    32'h1);
    checkOutput("cpu_wr_mem_a",  mem_a,              32'h10);
    checkOutput("cpu_wr_mem_wd", mem_wd,             32'hDEAD_BEEF);
    checkOutput("cpu_wr_stall",  {31'b0, cpu_stall}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("cpu_rd_data",   cpu_rdata,          32'hDEAD_BEEF);
    checkOutput("cpu_rd_mem_we", {31'b0, mem_we},    32'h0);

    // Preload words later used to prove an aborted burst stopped writing
    applyStimulus(1'b1, 1'b1, 32'h68, 32'h5A5A_0000, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h6C, 32'h5A5A_0001, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);

    // I/O write burst, 4 words at 0x20; request fields scrambled after ack
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 4'd4, 32'h0);
    checkOutput("wb_ack",      {31'b0, io_ack},  32'h1);
    checkOutput("wb_ack_we",   {31'b0, mem_we},  32'h0);
    checkOutput("wb_ack_beat", {31'b0, io_beat}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFF0, 4'd1, 32'h1000 + i);
      checkOutput($sformatf("wb_beat%0d", i),  {31'b0, io_beat}, 32'h1);
      checkOutput($sformatf("wb_idx%0d", i),   {28'b0, io_idx},  i);
      checkOutput($sformatf("wb_a%0d", i),     mem_a,            32'h20 + 4 * i);
      checkOutput($sformatf("wb_we%0d", i),    {31'b0, mem_we},  32'h1);
      checkOutput($sformatf("wb_wd%0d", i),    mem_wd,           32'h1000 + i);
      checkOutput($sformatf("wb_ack%0d", i),   {31'b0, io_ack},  32'h0);
      checkOutput($sformatf("wb_done%0d", i),  {31'b0, io_done}, 32'h0);
    end
    idleCycle();
    checkOutput("wb_done",      {31'b0, io_done}, 32'h1);
    checkOutput("wb_done_beat", {31'b0, io_beat}, 32'h0);
    checkOutput("wb_done_we",   {31'b0, mem_we},  32'h0);
    idleCycle();
    checkOutput("wb_after_done", {31'b0, io_done}, 32'h0);

    // I/O read burst of 2 words from 0x24
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 4'd2, 32'h0);
    checkOutput("rb_ack", {31'b0, io_ack}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 4'd2, 32'h0);
      checkOutput($sformatf("rb_data%0d", i), io_rdata,         32'h1001 + i);
      checkOutput($sformatf("rb_we%0d", i),   {31'b0, mem_we},  32'h0);
    end
    idleCycle();
    checkOutput("rb_done", {31'b0, io_done}, 32'h1);

    // Length 0 means 16 words; base low bits are dropped
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3, 4'd0, 32'h0);
    checkOutput("l16_ack", {31'b0, io_ack}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3, 4'd0, 32'h2000 + i);
      checkOutput($sformatf("l16_beat%0d", i), {31'b0, io_beat}, 32'h1);
      checkOutput($sformatf("l16_a%0d", i),    mem_a,            4 * i);
      checkOutput($sformatf("l16_idx%0d", i),  {28'b0, io_idx},  i);
    end
    idleCycle();
    checkOutput("l16_done", {31'b0, io_done}, 32'h1);
    idleCycle();

    // Contention: CPU holds a read of 0x10, I/O forced in after 8 cycles
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 4'd2, 32'h0);
      checkOutput($sformatf("st_ack%0d", k),   {31'b0, io_ack},    32'h0);
      checkOutput($sformatf("st_stall%0d", k), {31'b0, cpu_stall}, 32'h0);
      checkOutput($sformatf("st_rd%0d", k),    cpu_rdata,          32'h2004);
    end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 4'd2, 32'h0);
    checkOutput("st_grant_ack",   {31'b0, io_ack},    32'h1);
    checkOutput("st_grant_stall", {31'b0, cpu_stall}, 32'h1);
    checkOutput("st_grant_we",    {31'b0, mem_we},    32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 4'd2, 32'h4000 + i);
      checkOutput($sformatf("st_bstall%0d", i), {31'b0, cpu_stall}, 32'h1);
      checkOutput($sformatf("st_ba%0d", i),     mem_a,              32'h40 + 4 * i);
      checkOutput($sformatf("st_bwe%0d", i),    {31'b0, mem_we},    32'h1);
    end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("st_done",       {31'b0, io_done},   32'h1);
    checkOutput("st_done_stall", {31'b0, cpu_stall}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("st_resume_stall", {31'b0, cpu_stall}, 32'h0);
    checkOutput("st_resume_a",     mem_a,              32'h10);
    checkOutput("st_resume_rd",    cpu_rdata,          32'h2004);

    // Reset during beat 2 of a 4-word write burst at 0x60
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h60, 4'd4, 32'h0);
    checkOutput("rm_ack", {31'b0, io_ack}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h60, 4'd4, 32'h3000 + i);
    end
    @(negedge clk);
    io_wdata = 32'h3002;
    rst_n    = 1'b0;
    #1;
    checkOutput("rm_beat", {31'b0, io_beat}, 32'h0);
    checkOutput("rm_we",   {31'b0, mem_we},  32'h0);
    checkOutput("rm_a",    mem_a,            32'h0);
    checkOutput("rm_idx",  {28'b0, io_idx},  32'h0);
    checkOutput("rm_done", {31'b0, io_done}, 32'h0);
    idleCycle();
    rst_n = 1'b1;
    idleCycle();
    checkOutput("rm_post_done", {31'b0, io_done}, 32'h0);
    checkOutput("rm_post_beat", {31'b0, io_beat}, 32'h0);
    checkOutput("rm_ram24", ram[24], 32'h3000);
    checkOutput("rm_ram25", ram[25], 32'h3001);
    checkOutput("rm_ram26", ram[26], 32'h5A5A_0000);
    checkOutput("rm_ram27", ram[27], 32'h5A5A_0001);

    // CPU write to word 102, one past the RAM when bounds checking is on
    applyStimulus(1'b1, 1'b1, 32'h198, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
`ifdef ARB_BOUNDS_CHECK_EN
    checkOutput("bc_we", {31'b0, mem_we}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("bc_err",        {31'b0, err}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("bc_err_sticky", {31'b0, err}, 32'h1);
`else
    checkOutput("nb_we", {31'b0, mem_we}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h198, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
    checkOutput("nb_err", {31'b0, err}, 32'h0);
    checkOutput("nb_rd",  cpu_rdata,    32'hBAD0_BAD0);
`endif
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
